// File: rtl/core_ctrl_if.sv
// core_ctrl_if: memory handshakes, decode hints and state-update strobes between the sequencer and the datapath.
interface core_ctrl_if #(parameter int W = 32);
  logic         imem_req;
  logic         imem_ack;
  logic         ir_we;
  logic [6:0]   opcode;
  logic         wb_reg;
  logic         csr_wb;
  logic         dmem_req;
  logic         dmem_we;
  logic         dmem_ack;
  logic         pc_we;
  logic         reg_we;
  logic         csr_we;
  logic         illegal;
  logic         halt_req;
  logic         halted;
  logic [2:0]   state;
  logic [W-1:0] instret;
  modport master (
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, csr_we, illegal, halted, state, instret,
    input  imem_ack, opcode, wb_reg, csr_wb, dmem_ack, halt_req
  );
  modport slave (
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, csr_we, illegal, halted, state, instret,
    output imem_ack, opcode, wb_reg, csr_wb, dmem_ack, halt_req
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer gating every architectural state update.
// Optional retired-instruction counter enabled by defining CORE_CTRL_INSTRET_EN.
module core_ctrl #(
  parameter int RESET_STATE_CNT_W = 32
) (
  input logic       clk,
  input logic       rst,
  core_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t cur, nxt;
  logic is_store, is_mem, legal, fetch, mem, wb, halt;
  always_comb begin
    is_store = bus.opcode == 7'b0100011;
    is_mem   = is_store || bus.opcode == 7'b0000011;
    legal    = bus.opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};
    fetch    = !rst && cur == FETCH;
    mem      = !rst && cur == MEM;
    wb       = !rst && cur == WB;
    halt     = !rst && cur == HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:   nxt = bus.imem_ack ? DECODE : FETCH;
      DECODE:  nxt = EXEC;
      EXEC:    nxt = is_mem ? MEM : WB;
      MEM:     nxt = bus.dmem_ack ? WB : MEM;
      WB:      nxt = bus.halt_req ? HALT : FETCH;
      default: nxt = HALT;
    endcase
  end
  // An illegal opcode still advances the PC but never touches rd or a CSR.
  assign bus.imem_req = fetch;
  assign bus.ir_we    = fetch && bus.imem_ack;
  assign bus.dmem_req = mem;
  assign bus.dmem_we  = mem && is_store;
  assign bus.pc_we    = wb;
  assign bus.reg_we   = wb && legal && bus.wb_reg;
  assign bus.csr_we   = wb && legal && bus.csr_wb;
  assign bus.illegal  = wb && !legal;
  assign bus.halted   = halt;
  assign bus.state    = cur;
`ifdef CORE_CTRL_INSTRET_EN
  logic [RESET_STATE_CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (wb) cnt <= cnt + RESET_STATE_CNT_W'(1);
  end
  assign bus.instret = cnt;
`else
  assign bus.instret = '0;
`endif
endmodule
